mmio_port_responder: RTL and testbench
======================================

Name: mmio_port_responder

Overview:
- Memory-mapped I/O responder on the processor data bus.
- Owns the 32-bit output port register that drives PortOut.
- Synchronizes the 8-bit PortIn and detects changes on it, with sticky status and an optional interrupt line.
- Sits beside data memory and answers loads/stores whose address falls in its 16-byte window.

Parameters:
- BASE_ADDRESS, 32'h1001_0020, window base; must be 16-byte aligned.
- RESET_OUT, 32'h0000_0000, value of the PORT_OUT register after reset.
- ARM_CYCLES, 3, clocks after reset release during which change detection is suppressed (legal range 1-15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- MemWrite  input  1  store strobe from the processor.
- MemRead  input  1  load strobe from the processor.
- Address  input  32  byte address from the ALU result.
- WriteData  input  32  store data (ReadData2).
- ReadData  output  32  load data; combinational.
- Hit  output  1  address decodes to this block; combinational.
- PortIn  input  8  asynchronous external inputs.
- PortOut  output  32  output port register value.
- PortOutStrobe  output  1  one-clock pulse following each PORT_OUT write.
- InChangeIrq  output  1  change interrupt, level.

Behaviour:
- Decode:
  - Hit = (Address[31:4] == BASE_ADDRESS[31:4]) && (Address[1:0] == 0).
  - Offset = Address[3:2].
  - Misaligned or out-of-window accesses: Hit=0, no state change, ReadData=0.
- Register map:
  - 0x0 PORT_OUT: read/write, 32 bits.
  - 0x4 PORT_IN: read-only; returns {24'b0, sync2}.
  - 0x8 STATUS: read-only; returns {15'b0, OVF, CHG_MASK[7:0], 7'b0, CHG}.
  - 0xC CONTROL: read returns {30'b0, IRQ_EN, 1'b0}.
    - Write bit0 = CLR, self-clearing, never stored.
    - Write bit1 = IRQ_EN, stored.
- Reads: ReadData = (MemRead && Hit) ? selected register : 32'h0, evaluated on current register state.
- Writes: take effect on the rising clk edge when MemWrite && Hit. Writes to 0x4 and 0x8 are ignored.
- MemRead and MemWrite together: ReadData shows the pre-edge value; the write lands at the edge.
- PortOut equals PORT_OUT continuously.
- PortOutStrobe:
  - Registered; high for exactly the one clock following the edge that wrote PORT_OUT.
  - Back-to-back writes hold it high for consecutive cycles.
  - Asserts even if the written value equals the old value.
- Input path: sync1 <= PortIn; sync2 <= sync1; prev <= sync2. A PortIn change is readable at 0x4 after 2 edges.
- Arming:
  - 4-bit arm_cnt resets to 0 and increments each clock until it reaches ARM_CYCLES, then holds.
  - armed = (arm_cnt == ARM_CYCLES).
  - While not armed, prev still tracks sync2 but no change is recorded.
- Change detection, diff = sync2 ^ prev, when armed and diff != 0:
  - If CHG=0: CHG<=1, CHG_MASK<=diff.
  - If CHG=1: CHG_MASK<=CHG_MASK|diff, OVF<=1.
- CLR write: clears CHG, CHG_MASK and OVF.
- CLR and a new change at the same edge: the new change wins. Result is CHG=1, CHG_MASK=diff, OVF=0.
- InChangeIrq = CHG && IRQ_EN, combinational from registers.
- Reset (asynchronous assert, any time including mid-access), all take their values immediately:
  - PORT_OUT=RESET_OUT.
  - sync1, sync2, prev, arm_cnt, CHG, CHG_MASK, OVF, IRQ_EN and PortOutStrobe = 0.
  - Hence InChangeIrq=0.
- Latency summary: PortIn to CHG set is 3 edges (once armed). A write reaches PortOut at the same edge.
- Implementation size: approx. 150-220 lines of RTL.

Test Plan:
- Reset release with PortIn=8'hA5 held:
  - 0x4 reads 32'hA5 after 2 clocks.
  - STATUS stays 0 (arming suppression).
  - PortOut=RESET_OUT.
- Store 32'hDEAD_BEEF to BASE+0x0:
  - PortOut=32'hDEADBEEF from that edge.
  - PortOutStrobe high for exactly one clock.
  - Load of BASE+0x0 returns 32'hDEADBEEF.
- After arming, PortIn 8'h00->8'h03:
  - STATUS=32'h0000_0301 three edges later.
  - A second change 8'h03->8'h13 before clear gives STATUS=32'h0001_1301.
- Write CONTROL=32'h2 then trigger a change:
  - InChangeIrq rises with CHG.
  - Write CONTROL=32'h3: STATUS=0 and IRQ drops. CONTROL then reads 32'h2.
- CLR write coincident with a new diff=8'h80: STATUS=32'h0000_8001 after the edge.
- Store to BASE+0x2 (misaligned) and to BASE+0x10:
  - Hit=0, PORT_OUT unchanged, ReadData=0.
- Assert reset mid-write cycle: PortOut returns to RESET_OUT asynchronously and the write is lost.

Source files
------------

// File: rtl/mmio_port_responder.sv
// mmio_port_responder: 16-byte MMIO window holding a 32-bit output port register
// and a synchronized, change-detecting 8-bit input port with sticky status and IRQ.
module mmio_port_responder #(
   parameter logic [31:0] BASE_ADDRESS = 32'h1001_0020,
   parameter logic [31:0] RESET_OUT    = 32'h0000_0000,
   parameter int unsigned ARM_CYCLES   = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic        MemRead,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Hit,
   input  logic [7:0]  PortIn,
   output logic [31:0] PortOut,
   output logic        PortOutStrobe,
   output logic        InChangeIrq
);
   logic [31:0] port_out;
   logic        strobe, chg, ovf, irq_en;
   logic [7:0]  sync1, sync2, prev, chg_mask, diff;
   logic [3:0]  arm_cnt;
   logic [1:0]  offset;
   logic        wr, clr, armed, change;
   logic [31:0] sel;

   assign Hit    = (Address[31:4] == BASE_ADDRESS[31:4]) && (Address[1:0] == 2'b00);
   assign offset = Address[3:2];
   assign wr     = MemWrite && Hit;
   assign clr    = wr && (offset == 2'd3) && WriteData[0];
   assign armed  = arm_cnt == 4'(ARM_CYCLES);
   assign diff   = sync2 ^ prev;
   assign change = armed && (diff != 8'h00);

   always_comb begin
      sel = (offset == 2'd0) ? port_out :
            (offset == 2'd1) ? {24'h0, sync2} :
            (offset == 2'd2) ? {15'h0, ovf, chg_mask, 7'h0, chg} :
                               {30'h0, irq_en, 1'b0};
      ReadData = (MemRead && Hit) ? sel : 32'h0;
   end

   assign PortOut       = port_out;
   assign PortOutStrobe = strobe;
   assign InChangeIrq   = chg && irq_en;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         port_out <= RESET_OUT;
         strobe   <= 1'b0;
         sync1    <= 8'h00;
         sync2    <= 8'h00;
         prev     <= 8'h00;
         arm_cnt  <= 4'h0;
         chg      <= 1'b0;
         chg_mask <= 8'h00;
         ovf      <= 1'b0;
         irq_en   <= 1'b0;
      end else begin
         strobe <= wr && (offset == 2'd0);
         if (wr && offset == 2'd0) port_out <= WriteData;
         if (wr && offset == 2'd3) irq_en <= WriteData[1];
         sync1 <= PortIn;
         sync2 <= sync1;
         prev  <= sync2;
         if (!armed) arm_cnt <= arm_cnt + 4'h1;
         // a coincident clear yields to the new change, which restarts the sticky record
         if (change && chg && !clr) begin
            chg_mask <= chg_mask | diff;
            ovf      <= 1'b1;
         end else if (change) begin
            chg      <= 1'b1;
            chg_mask <= diff;
            ovf      <= 1'b0;
         end else if (clr) begin
            chg      <= 1'b0;
            chg_mask <= 8'h00;
            ovf      <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_mmio_port_responder.sv
// tb_mmio_port_responder: randomized scoreboard bench; a history-based reference model
// predicts every cycle's outputs and a negedge monitor compares them.
module tb_mmio_port_responder;
   localparam logic [31:0] B   = 32'h1001_0020;
   localparam logic [31:0] RST = 32'h5A5A_0F0F;
   localparam int          ARM = 3;

   logic        clk = 0, reset = 0, MemWrite = 0, MemRead = 0;
   logic [31:0] Address = 0, WriteData = 0, ReadData, PortOut;
   logic        Hit, PortOutStrobe, InChangeIrq;
   logic [7:0]  PortIn = 0;

   mmio_port_responder #(.BASE_ADDRESS(B), .RESET_OUT(RST), .ARM_CYCLES(ARM)) dut (
      .clk(clk), .reset(reset), .MemWrite(MemWrite), .MemRead(MemRead),
      .Address(Address), .WriteData(WriteData), .ReadData(ReadData), .Hit(Hit),
      .PortIn(PortIn), .PortOut(PortOut), .PortOutStrobe(PortOutStrobe),
      .InChangeIrq(InChangeIrq)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        hit, strobe, irq;
      logic [31:0] pout, rd;
   } obs_t;

   obs_t exp_q[$];
   int vectors = 0, miscompares = 0;

   // model: PortIn value captured at each edge since reset release
   logic [7:0]  hist[$];
   int          n;
   logic [31:0] m_out;
   logic        m_strobe, m_chg, m_ovf, m_irq_en;
   logic [7:0]  m_mask;

   function automatic logic [7:0] pin_at(int j);
      return (j < 1) ? 8'h00 : hist[j-1];
   endfunction

   function automatic void model_reset();
      hist.delete();
      n = 0;
      m_out = RST;
      m_strobe = 0; m_chg = 0; m_ovf = 0; m_irq_en = 0; m_mask = 0;
   endfunction

   function automatic logic [31:0] m_reg(logic [1:0] off);
      case (off)
         2'd0:    return m_out;
         2'd1:    return 32'(pin_at(n - 1));
         2'd2:    return (32'(m_ovf) << 16) + (32'(m_mask) << 8) + 32'(m_chg);
         default: return 32'(m_irq_en) * 2;
      endcase
   endfunction

   function automatic void model_edge(logic w, logic [1:0] off, logic [31:0] wd, logic [7:0] pin);
      logic [7:0] d;
      logic clr;
      n++;
      hist.push_back(pin);
      clr = w && off == 3 && wd[0];
      d = pin_at(n - 2) ^ pin_at(n - 3);
      m_strobe = w && off == 0;
      if (w && off == 0) m_out = wd;
      if (w && off == 3) m_irq_en = wd[1];
      if ((n - 1) >= ARM && d != 0) begin
         if (m_chg && !clr) begin
            m_mask = m_mask | d;
            m_ovf = 1;
         end else begin
            m_chg = 1; m_mask = d; m_ovf = 0;
         end
      end else if (clr) begin
         m_chg = 0; m_mask = 0; m_ovf = 0;
      end
   endfunction

   function automatic logic is_hit(logic [31:0] a);
      return (a[31:4] == B[31:4]) && (a[1:0] == 2'b00);
   endfunction

   function automatic void push_expect(logic re, logic [31:0] a);
      obs_t e;
      e.hit = is_hit(a);
      e.strobe = m_strobe;
      e.irq = m_chg && m_irq_en;
      e.pout = m_out;
      e.rd = (re && e.hit) ? m_reg(a[3:2]) : 32'h0;
      exp_q.push_back(e);
   endfunction

   task automatic cyc(input logic we, input logic re, input logic [31:0] a,
                      input logic [31:0] wd, input logic [7:0] pin);
      MemWrite = we; MemRead = re; Address = a; WriteData = wd; PortIn = pin;
      push_expect(re, a);
      @(posedge clk);
      if (!reset) model_reset();
      else model_edge(we && is_hit(a), a[3:2], wd, pin);
      #1;
   endtask

   task automatic mid_reset(input logic [31:0] wd);
      MemWrite = 1; MemRead = 1; Address = B; WriteData = wd;
      push_expect(1, B);
      @(negedge clk);
      #2 reset = 0;
      #1;
      vectors++;
      if (PortOut !== RST || PortOutStrobe !== 1'b0 || InChangeIrq !== 1'b0) begin
         miscompares++;
         $display("FAIL async_reset: PortOut=%h strobe=%b irq=%b, required PortOut=%h strobe=0 irq=0",
                  PortOut, PortOutStrobe, InChangeIrq, RST);
      end
      @(posedge clk);
      model_reset();
      #1;
      MemWrite = 0;
      reset = 1;
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         obs_t e, a;
         e = exp_q.pop_front();
         a = {Hit, PortOutStrobe, InChangeIrq, PortOut, ReadData};
         vectors++;
         if (a !== e) begin
            miscompares++;
            $display("FAIL obs @%0t addr=%h: got hit=%b stb=%b irq=%b out=%h rd=%h, required hit=%b stb=%b irq=%b out=%h rd=%h",
                     $time, Address, a.hit, a.strobe, a.irq, a.pout, a.rd,
                     e.hit, e.strobe, e.irq, e.pout, e.rd);
         end
      end
   end

   initial begin
      logic [31:0] a;
      logic [7:0]  pin;
      model_reset();
      @(posedge clk); #1;
      cyc(0, 1, B, 0, 8'hA5);
      cyc(0, 1, B, 0, 8'hA5);
      reset = 1;
      repeat (4) cyc(0, 1, B + 4, 0, 8'hA5);
      repeat (4) cyc(0, 1, B + 8, 0, 8'hA5);
      cyc(1, 0, B, 32'hDEAD_BEEF, 8'hA5);
      repeat (3) cyc(0, 1, B, 0, 8'hA5);
      repeat (5) cyc(0, 1, B + 8, 0, 8'h00);
      cyc(1, 0, B + 12, 32'h1, 8'h00);
      repeat (4) cyc(0, 1, B + 8, 0, 8'h03);
      repeat (4) cyc(0, 1, B + 8, 0, 8'h13);
      cyc(1, 0, B + 12, 32'h3, 8'h13);
      cyc(0, 1, B + 12, 0, 8'h13);
      repeat (4) cyc(0, 1, B + 8, 0, 8'h17);
      cyc(1, 1, B + 12, 32'h3, 8'h17);
      cyc(0, 1, B + 8, 0, 8'h17);
      cyc(0, 1, B + 12, 0, 8'h17);
      cyc(0, 1, B + 8, 0, 8'h97);
      cyc(0, 1, B + 8, 0, 8'h97);
      cyc(1, 1, B + 12, 32'h3, 8'h97);
      repeat (2) cyc(0, 1, B + 8, 0, 8'h97);
      cyc(1, 1, B + 2, 32'h5555_5555, 8'h97);
      cyc(1, 1, B + 16, 32'h6666_6666, 8'h97);
      cyc(0, 1, B, 0, 8'h97);
      cyc(1, 0, B, 32'h1234_5678, 8'h97);
      mid_reset(32'hFFFF_0000);
      repeat (3) cyc(0, 1, B, 0, 8'h97);
      pin = 8'h97;
      for (int i = 0; i < 1500; i++) begin
         case ($urandom_range(0, 7))
            0, 1, 2, 3: a = B + 32'(4 * $urandom_range(0, 3));
            4:          a = B + 32'($urandom_range(1, 3));
            5:          a = B + 16;
            6:          a = B - 4;
            default:    a = $urandom;
         endcase
         if ($urandom_range(0, 3) == 0) pin = 8'($urandom);
         if ($urandom_range(0, 299) == 0) mid_reset($urandom);
         else cyc($urandom_range(0, 2) == 0, 1'($urandom), a, $urandom, pin);
      end
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      if (exp_q.size() > 0) begin
         miscompares++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
